uncache_axi_bridge: RTL and testbench

Responder end of the uncached-access request interface: accepts one registered uncached request (enable, byte write-select, address, write data) from the CPU-side uncached tag logic. Performs it as a single-beat AXI master transaction, then returns a one-cycle completion pulse plus read data. Sits between the data-side uncached tag block and the AXI crossbar. One request outstanding at a time.

---
 rtl/uncache_axi_bridge.sv | 146 ++++++++++++++
 tb/tb_uncache_axi_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_axi_bridge.sv
// Uncached-access responder: turns one registered CPU uncached request into a single-beat
// AXI read or write, then returns a one-cycle completion pulse plus registered read data.
module uncache_axi_bridge #(
  parameter logic [3:0] ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // uncached request interface
  input  logic        uc_en,
  input  logic [3:0]  uc_wsel,
  input  logic [31:0] uc_addr,
  input  logic [31:0] uc_wdata,
  output logic        uc_refresh,
  output logic [31:0] uc_rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAww, StB, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wsel_q;
  logic        aw_done_q, w_done_q;

  // Responses are never inspected; errors complete like OKAY.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (uc_en) state_d = (uc_wsel == 4'b0000) ? StAr : StAww;
      end
      StAr:   if (arready) state_d = StR;
      StR:    if (rvalid && rlast) state_d = StResp;
      // Both channels may complete in the same cycle or in either order.
      StAww:  if ((aw_done_q || awready) && (w_done_q || wready)) state_d = StB;
      StB:    if (bvalid) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arvalid    = (state_q == StAr);
    rready     = (state_q == StR);
    awvalid    = (state_q == StAww) && !aw_done_q;
    wvalid     = (state_q == StAww) && !w_done_q;
    bready     = (state_q == StB);
    uc_refresh = (state_q == StResp);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wsel_q    <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && uc_en) begin
        addr_q  <= uc_addr;
        wdata_q <= uc_wdata;
        wsel_q  <= uc_wsel;
      end
      if (state_q == StR && rvalid && rlast) begin
        rdata_q <= rdata;
      end
      if (state_q == StAww) begin
        aw_done_q <= aw_done_q || awready;
        w_done_q  <= w_done_q || wready;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    case (wsel_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize = 3'b000;
      4'b0011, 4'b1100:                   awsize = 3'b001;
      default:                            awsize = 3'b010;
    endcase
  end

  assign uc_rdata = rdata_q;
  assign arid     = ID;
  assign araddr   = addr_q;
  assign arlen    = 8'd0;
  assign arsize   = 3'b010;
  assign arburst  = 2'b01;
  assign awid     = ID;
  assign awaddr   = addr_q;
  assign awlen    = 8'd0;
  assign awburst  = 2'b01;
  assign wid      = ID;
  assign wdata    = wdata_q;
  assign wstrb    = wsel_q;
  assign wlast    = 1'b1;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Directed bench for uncache_axi_bridge: a configurable-wait AXI slave model plus
// one task per scenario, each comparing recorded per-cycle outputs against hand values.
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        uc_en = 1'b0;
  logic [3:0]  uc_wsel = '0;
  logic [31:0] uc_addr = '0, uc_wdata = '0;
  logic        uc_refresh;
  logic [31:0] uc_rdata;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int total = 0, bad = 0;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int ar_hs = 0, refresh_cnt = 0;
  logic [31:0] slv_rdata = '0;

  logic        rec_arvalid [0:63];
  logic        rec_rready  [0:63];
  logic        rec_awvalid [0:63];
  logic        rec_wvalid  [0:63];
  logic        rec_bready  [0:63];
  logic        rec_wlast   [0:63];
  logic [31:0] rec_araddr  [0:63];
  logic [31:0] rec_awaddr  [0:63];
  logic [31:0] rec_wdata   [0:63];
  logic [3:0]  rec_wstrb   [0:63];
  logic [2:0]  rec_awsize  [0:63];

  always #5 clk = ~clk;

  uncache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .uc_en(uc_en), .uc_wsel(uc_wsel), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_refresh(uc_refresh), .uc_rdata(uc_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Slave model: each ready/valid response comes after a programmable number of waiting cycles.
  assign arready = arvalid && (ar_cnt >= ar_wait);
  assign rvalid  = rready && (r_cnt >= r_wait);
  assign rlast   = rvalid;
  assign rdata   = rvalid ? slv_rdata : 32'hDEAD_BEEF;
  assign rid     = 4'd1;
  assign rresp   = 2'b10;
  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign bvalid  = bready && (b_cnt >= b_wait);
  assign bid     = 4'd1;
  assign bresp   = 2'b00;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      r_cnt  <= (rready && !rvalid) ? r_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      b_cnt  <= (bready && !bvalid) ? b_cnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
    if (uc_refresh) refresh_cnt <= refresh_cnt + 1;
  end

  // Issue one request, hold uc_en until the refresh edge, record outputs per cycle.
  // lat = cycle index (request-sampling edge is cycle 0) at which uc_refresh is seen.
  task automatic do_req(input logic [3:0] wsel, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat);
    for (int i = 0; i < 64; i++) begin
      rec_arvalid[i] = 0; rec_rready[i] = 0; rec_awvalid[i] = 0; rec_wvalid[i] = 0;
      rec_bready[i] = 0; rec_wlast[i] = 0; rec_araddr[i] = 0; rec_awaddr[i] = 0;
      rec_wdata[i] = 0; rec_wstrb[i] = 0; rec_awsize[i] = 0;
    end
    @(negedge clk);
    uc_en = 1'b1; uc_wsel = wsel; uc_addr = addr; uc_wdata = wd;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n < 60; n++) begin
      #1;
      rec_arvalid[n] = arvalid; rec_rready[n] = rready; rec_awvalid[n] = awvalid;
      rec_wvalid[n] = wvalid; rec_bready[n] = bready; rec_wlast[n] = wlast;
      rec_araddr[n] = araddr; rec_awaddr[n] = awaddr; rec_wdata[n] = wdata;
      rec_wstrb[n] = wstrb; rec_awsize[n] = awsize;
      if (uc_refresh) begin
        lat = n;
        break;
      end
      @(posedge clk);
    end
    total++;
    if (lat == 0) begin
      bad++;
      $display("FAIL req_timeout: no uc_refresh within 59 cycles (addr=%h)", addr);
    end
    @(posedge clk);
    #1;
    uc_en = 1'b0;
    total++;
    if (uc_refresh !== 1'b0) begin
      bad++;
      $display("FAIL refresh_width: uc_refresh=%b after pulse cycle, expected 0", uc_refresh);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, uc_refresh} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {arvalid, rready, awvalid, wvalid, bready, uc_refresh});
    end
    total++;
    if ({uc_rdata, araddr, awaddr, wdata, wstrb} !== 132'h0) begin
      bad++;
      $display("FAIL reset_data: rdata=%h araddr=%h awaddr=%h wdata=%h wstrb=%h expected 0",
               uc_rdata, araddr, awaddr, wdata, wstrb);
    end
    total++;
    if ({arlen, arsize, arburst, awlen, awsize, awburst, wlast} !== {8'd0, 3'd2, 2'd1,
        8'd0, 3'd2, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL reset_const: arlen=%0d arsize=%0d arburst=%0d awlen=%0d awsize=%0d awburst=%0d wlast=%b",
               arlen, arsize, arburst, awlen, awsize, awburst, wlast);
    end
    total++;
    if ({arid, awid, wid} !== 12'h111) begin
      bad++;
      $display("FAIL reset_ids: got %h expected 111", {arid, awid, wid});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_read_zero();
    int lat;
    ar_wait = 0; r_wait = 0; slv_rdata = 32'h0000_00A5;
    do_req(4'b0000, 32'hBFD0_03F8, 32'h0, lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL read0_latency: got %0d expected 3", lat); end
    total++;
    if (rec_arvalid[1] !== 1'b1 || rec_araddr[1] !== 32'hBFD0_03F8 || arsize !== 3'd2) begin
      bad++;
      $display("FAIL read0_ar: arvalid=%b araddr=%h arsize=%0d expected 1 BFD003F8 2",
               rec_arvalid[1], rec_araddr[1], arsize);
    end
    total++;
    if (rec_arvalid[2] !== 1'b0 || rec_rready[2] !== 1'b1) begin
      bad++;
      $display("FAIL read0_r: cycle2 arvalid=%b rready=%b expected 0 1",
               rec_arvalid[2], rec_rready[2]);
    end
    total++;
    if (uc_rdata !== 32'h0000_00A5) begin
      bad++; $display("FAIL read0_data: got %h expected 000000a5", uc_rdata);
    end
  endtask

  task automatic test_byte_write();
    int lat;
    aw_wait = 0; w_wait = 0; b_wait = 2;
    do_req(4'b0100, 32'hBFD0_03FA, 32'h00CC_0000, lat);
    total++;
    if (rec_awvalid[1] !== 1'b1 || rec_wvalid[1] !== 1'b1 || rec_awsize[1] !== 3'd0 ||
        rec_wstrb[1] !== 4'b0100 || rec_wlast[1] !== 1'b1) begin
      bad++;
      $display("FAIL bytew_chan: awv=%b wv=%b awsize=%0d wstrb=%b wlast=%b expected 1 1 0 0100 1",
               rec_awvalid[1], rec_wvalid[1], rec_awsize[1], rec_wstrb[1], rec_wlast[1]);
    end
    total++;
    if (rec_awaddr[1] !== 32'hBFD0_03FA || rec_wdata[1] !== 32'h00CC_0000) begin
      bad++;
      $display("FAIL bytew_addr: awaddr=%h wdata=%h expected bfd003fa 00cc0000",
               rec_awaddr[1], rec_wdata[1]);
    end
    // bvalid comes in cycle 4 after two wait cycles in B
    total++;
    if (lat != 5) begin bad++; $display("FAIL bytew_latency: got %0d expected 5", lat); end
    total++;
    if (uc_rdata !== 32'h0000_00A5) begin
      bad++; $display("FAIL bytew_rdata_hold: got %h expected 000000a5", uc_rdata);
    end
    b_wait = 0;
  endtask

  task automatic test_awsize();
    logic [3:0] strb [0:3];
    logic [2:0] size [0:3];
    int lat;
    strb[0] = 4'b0011; size[0] = 3'd1;
    strb[1] = 4'b1100; size[1] = 3'd1;
    strb[2] = 4'b1111; size[2] = 3'd2;
    strb[3] = 4'b0110; size[3] = 3'd2;
    for (int i = 0; i < 4; i++) begin
      do_req(strb[i], 32'h1FC0_0000 + i * 4, 32'h1234_5678, lat);
      total++;
      if (rec_awsize[1] !== size[i] || lat != 3) begin
        bad++;
        $display("FAIL awsize_%0d: strb=%b awsize=%0d lat=%0d expected %0d 3",
                 i, strb[i], rec_awsize[1], lat, size[i]);
      end
    end
  endtask

  task automatic test_split_write();
    int lat;
    aw_wait = 3; w_wait = 0;
    do_req(4'b1111, 32'h1FD0_0010, 32'hCAFE_F00D, lat);
    total++;
    if (rec_wvalid[2] !== 1'b0 || rec_awvalid[2] !== 1'b1 || rec_awvalid[4] !== 1'b1 ||
        rec_awvalid[5] !== 1'b0) begin
      bad++;
      $display("FAIL split_aw_late: wv2=%b awv2=%b awv4=%b awv5=%b expected 0 1 1 0",
               rec_wvalid[2], rec_awvalid[2], rec_awvalid[4], rec_awvalid[5]);
    end
    total++;
    if (rec_bready[4] !== 1'b0 || rec_bready[5] !== 1'b1 || lat != 6) begin
      bad++;
      $display("FAIL split_aw_late_b: bready4=%b bready5=%b lat=%0d expected 0 1 6",
               rec_bready[4], rec_bready[5], lat);
    end
    aw_wait = 0; w_wait = 3;
    do_req(4'b1111, 32'h1FD0_0014, 32'h0BAD_CAFE, lat);
    total++;
    if (rec_awvalid[2] !== 1'b0 || rec_wvalid[2] !== 1'b1 || rec_wvalid[4] !== 1'b1 ||
        rec_wvalid[5] !== 1'b0) begin
      bad++;
      $display("FAIL split_w_late: awv2=%b wv2=%b wv4=%b wv5=%b expected 0 1 1 0",
               rec_awvalid[2], rec_wvalid[2], rec_wvalid[4], rec_wvalid[5]);
    end
    total++;
    if (rec_bready[4] !== 1'b0 || rec_bready[5] !== 1'b1 || lat != 6) begin
      bad++;
      $display("FAIL split_w_late_b: bready4=%b bready5=%b lat=%0d expected 0 1 6",
               rec_bready[4], rec_bready[5], lat);
    end
    w_wait = 0;
  endtask

  task automatic test_backpressure();
    int lat, ref0, unstable;
    ar_wait = 4; r_wait = 5; slv_rdata = 32'h5A5A_0001;
    ref0 = refresh_cnt;
    unstable = 0;
    do_req(4'b0000, 32'hBFD0_0100, 32'h0, lat);
    for (int n = 1; n <= 5; n++) begin
      if (rec_arvalid[n] !== 1'b1 || rec_araddr[n] !== 32'hBFD0_0100) unstable++;
    end
    total++;
    if (unstable != 0 || rec_arvalid[6] !== 1'b0) begin
      bad++;
      $display("FAIL bp_ar_stable: %0d bad AR cycles, arvalid6=%b expected 0 0",
               unstable, rec_arvalid[6]);
    end
    total++;
    if (lat != 12) begin bad++; $display("FAIL bp_latency: got %0d expected 12", lat); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (refresh_cnt - ref0 != 1 || uc_rdata !== 32'h5A5A_0001) begin
      bad++;
      $display("FAIL bp_refresh: pulses=%0d rdata=%h expected 1 5a5a0001",
               refresh_cnt - ref0, uc_rdata);
    end
    ar_wait = 0; r_wait = 0;
  endtask

  task automatic test_reset_mid_read();
    int lat;
    r_wait = 20;
    @(negedge clk);
    uc_en = 1'b1; uc_wsel = 4'b0000; uc_addr = 32'hBFD0_0200;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rready !== 1'b1) begin bad++; $display("FAIL rst_mid_setup: rready=%b expected 1", rready); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({rready, arvalid, uc_refresh} !== 3'b000 || araddr !== 32'h0 || uc_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_async: rready=%b arvalid=%b refresh=%b araddr=%h rdata=%h expected 0",
               rready, arvalid, uc_refresh, araddr, uc_rdata);
    end
    uc_en = 1'b0;
    r_wait = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({arvalid, rready, uc_refresh} !== 3'b000) begin
      bad++;
      $display("FAIL rst_no_resume: arvalid=%b rready=%b refresh=%b expected 0",
               arvalid, rready, uc_refresh);
    end
    slv_rdata = 32'h1234_5678;
    do_req(4'b0000, 32'hBFD0_0204, 32'h0, lat);
    total++;
    if (lat != 3 || uc_rdata !== 32'h1234_5678 || rec_araddr[1] !== 32'hBFD0_0204) begin
      bad++;
      $display("FAIL rst_fresh_read: lat=%0d rdata=%h araddr=%h expected 3 12345678 bfd00204",
               lat, uc_rdata, rec_araddr[1]);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, ar0, ref0;
    ar0 = ar_hs;
    ref0 = refresh_cnt;
    slv_rdata = 32'hAAAA_0001;
    do_req(4'b0000, 32'hBFD0_0300, 32'h0, lat1);
    slv_rdata = 32'hBBBB_0002;
    do_req(4'b0000, 32'hBFD0_0304, 32'h0, lat2);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (ar_hs - ar0 != 2 || refresh_cnt - ref0 != 2) begin
      bad++;
      $display("FAIL b2b_count: ar_handshakes=%0d refreshes=%0d expected 2 2",
               ar_hs - ar0, refresh_cnt - ref0);
    end
    total++;
    if (lat1 != 3 || lat2 != 3 || uc_rdata !== 32'hBBBB_0002 || arvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result: lat1=%0d lat2=%0d rdata=%h arvalid=%b expected 3 3 bbbb0002 0",
               lat1, lat2, uc_rdata, arvalid);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_byte_write();
    test_awsize();
    test_split_write();
    test_backpressure();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
